// File: rtl/bp_lce_req_stream_pump.sv
// bp_lce_req_stream_pump
// Takes one complete LCE request message (header + full cache block) per
// ready->valid handshake and replays it on the request network as a stream:
// the registered header stays stable while fill_width_p-wide data beats are
// emitted, with last asserted on the final beat.
//
// Header layout (LSB first):
//   [3:0]  msg_type   0 rd, 1 wr, 2 uc_rd, 3 uc_wr, 4..12 amo variants
//   [6:4]  size       message size is 2^size bytes
//   then   addr (paddr_width_p), src lce id, dst cce id, way id
// The message places the header in the low bits with the data block above.

module bp_lce_req_stream_pump
  #(parameter int paddr_width_p     = 40
  , parameter int cce_block_width_p = 512
  , parameter int lce_id_width_p    = 4
  , parameter int cce_id_width_p    = 4
  , parameter int lce_assoc_p       = 8
  , parameter int fill_width_p      = 64
  , localparam int way_id_width_lp  = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1
  , localparam int lce_req_header_width_lp = 4 + 3 + paddr_width_p + lce_id_width_p
                                             + cce_id_width_p + way_id_width_lp
  , localparam int lce_req_msg_width_lp = lce_req_header_width_lp + cce_block_width_p
  , localparam int beats_lp        = cce_block_width_p / fill_width_p
  , localparam int cnt_width_lp    = (beats_lp > 1) ? $clog2(beats_lp) : 1
  )
  (input  logic                               clk_i
  , input  logic                               reset_i
  , input  logic [lce_req_msg_width_lp-1:0]    lce_req_i
  , input  logic                               lce_req_v_i
  , output logic                               lce_req_ready_o
  , output logic [lce_req_header_width_lp-1:0] lce_req_header_o
  , output logic [fill_width_p-1:0]            lce_req_data_o
  , output logic                               lce_req_v_o
  , input  logic                               lce_req_ready_and_i
  , output logic                               lce_req_last_o
  );

  localparam int fill_log_lp  = $clog2(fill_width_p);
  localparam int beats_log_lp = $clog2(beats_lp);

  typedef enum logic [0:0] {e_ready = 1'b0, e_send = 1'b1} state_e;

  // Only uncached writes and the atomics carry a payload.
  function automatic logic data_bearing_f(input logic [3:0] msg_type);
    logic result;
    case (msg_type)
      4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12: result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

  // Index of the final beat: payload bits / beat width, at least one beat,
  // never more than the block holds.
  function automatic logic [cnt_width_lp-1:0] last_beat_f(input logic [3:0] msg_type,
                                                          input logic [2:0] size);
    int bits_log;
    int n_beats;
    bits_log = int'(size) + 3;
    if (!data_bearing_f(msg_type)) begin
      n_beats = 1;
    end else if (bits_log <= fill_log_lp) begin
      n_beats = 1;
    end else if ((bits_log - fill_log_lp) >= beats_log_lp) begin
      n_beats = beats_lp;
    end else begin
      n_beats = 1 << (bits_log - fill_log_lp);
    end
    return cnt_width_lp'(n_beats - 1);
  endfunction

  state_e                                   state_r, state_s;
  logic [cnt_width_lp-1:0]                  cnt_r, cnt_s;
  logic [cnt_width_lp-1:0]                  last_idx_r;
  logic [lce_req_header_width_lp-1:0]       hdr_r;
  logic [beats_lp-1:0][fill_width_p-1:0]    data_r;
  logic                                     ready_r;
  logic                                     accept_s;

  logic [3:0] in_type_s;
  logic [2:0] in_size_s;
  assign in_type_s = lce_req_i[3:0];
  assign in_size_s = lce_req_i[6:4];

  // Next-state logic: accept in e_ready, advance beats on each network handshake.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      e_ready: begin
        if (lce_req_v_i && ready_r) begin
          accept_s = 1'b1;
          state_s  = e_send;
          cnt_s    = '0;
        end else begin
          state_s  = e_ready;
        end
      end
      e_send: begin
        if (lce_req_ready_and_i) begin
          if (cnt_r == last_idx_r) begin
            state_s = e_ready;
          end else begin
            cnt_s   = cnt_r + 1'b1;
          end
        end else begin
          state_s = e_send;
        end
      end
      default: begin
        state_s = e_ready;
        cnt_s   = '0;
      end
    endcase
  end

  // State and beat counter registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_ready;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Ready is registered so it stays low throughout reset and rises on the first edge after it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= (state_s == e_ready);
    end
  end

  // Message capture; header-only requests store a zero block so beat 0 reads zero.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hdr_r      <= '0;
      data_r     <= '0;
      last_idx_r <= '0;
    end else if (accept_s) begin
      hdr_r      <= lce_req_i[lce_req_header_width_lp-1:0];
      data_r     <= data_bearing_f(in_type_s)
                    ? lce_req_i[lce_req_msg_width_lp-1:lce_req_header_width_lp]
                    : '0;
      last_idx_r <= last_beat_f(in_type_s, in_size_s);
    end
  end

  assign lce_req_ready_o  = ready_r;
  assign lce_req_v_o      = (state_r == e_send);
  assign lce_req_last_o   = (state_r == e_send) && (cnt_r == last_idx_r);
  assign lce_req_header_o = hdr_r;
  assign lce_req_data_o   = data_r[cnt_r];

  bp_lce_req_stream_pump_chk
    #(.cnt_width_p(cnt_width_lp))
    chk
      (.clk_i           (clk_i)
      , .reset_i         (reset_i)
      , .lce_req_v_i     (lce_req_v_i)
      , .lce_req_ready_o (lce_req_ready_o)
      , .lce_req_v_o     (lce_req_v_o)
      , .cnt_i           (cnt_r)
      , .last_idx_i      (last_idx_r)
      );

endmodule

// Protocol checks for the stream pump; simulation only.
module bp_lce_req_stream_pump_chk
  #(parameter int cnt_width_p = 3)
  (input  logic                   clk_i
  , input  logic                   reset_i
  , input  logic                   lce_req_v_i
  , input  logic                   lce_req_ready_o
  , input  logic                   lce_req_v_o
  , input  logic [cnt_width_p-1:0] cnt_i
  , input  logic [cnt_width_p-1:0] last_idx_i
  );

  // Upstream must only present a message when we are ready.
  a_valid_needs_ready: assert property (@(posedge clk_i) disable iff (reset_i)
    lce_req_v_i |-> lce_req_ready_o);

  // The beat counter must stay within the message's beat range.
  a_cnt_bounded: assert property (@(posedge clk_i) disable iff (reset_i)
    lce_req_v_o |-> (cnt_i <= last_idx_i));

endmodule

// File: doc/bp_lce_req_stream_pump.md
# bp_lce_req_stream_pump

Downstream stage of the LCE request handler. Accepts one complete BedRock LCE request message (header plus full data field) per ready->valid handshake, registers it, and emits it on the LCE request network as a BedRock stream: header held stable across one or more `fill_width_p`-wide data beats, with a `last` flag on the final beat. Decouples the request handler's single-cycle message issue from a narrower, backpressured NoC link.

## Interface
Parameters:
- `bp_params_p`, `e_bp_default_cfg`: processor configuration; supplies `paddr_width_p`, `cce_block_width_p`, `lce_id_width_p`, `cce_id_width_p`, `lce_assoc_p`.
- `fill_width_p`, 64: stream data beat width in bits; power of two, 64 <= `fill_width_p` <= `cce_block_width_p`.
- `beats_lp` (local): `cce_block_width_p/fill_width_p`; beat counter width is `BSG_SAFE_CLOG2(beats_lp)`.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `reset_i`  in  1  reset; asynchronous, active-high.
- `lce_req_i`  in  `lce_req_msg_width_lp`  full request message (header + `cce_block_width_p` data).
- `lce_req_v_i`  in  1  message valid; ready->valid, asserted only when `lce_req_ready_o` is high.
- `lce_req_ready_o`  out  1  block can accept a message this cycle.
- `lce_req_header_o`  out  `lce_req_header_width_lp`  registered header.
- `lce_req_data_o`  out  `fill_width_p`  current data beat.
- `lce_req_v_o`  out  1  beat valid.
- `lce_req_ready_and_i`  in  1  network accepts beat when high with `lce_req_v_o`.
- `lce_req_last_o`  out  1  current beat is the final beat of the message.

## Operation
- Data-bearing types: `e_bedrock_req_uc_wr` and all nine `e_bedrock_req_amo*`. All others (`rd`, `wr`, `uc_rd`) are header-only.
- Beat count N: header-only -> N=1, data beat driven to zero. Data-bearing -> bytes = 2^size; N = max(1, bytes*8/`fill_width_p`), clamped to `beats_lp`.
- Beat k carries `data_r[k*fill_width_p +: fill_width_p]`; sizes below `fill_width_p` bits use beat 0 raw (upstream already places the payload in the low bits; no replication).
- FSM, two states:
  - `e_ready`: `lce_req_ready_o`=1, `lce_req_v_o`=0. On `lce_req_v_i`: capture header, data, compute last-beat index N-1, clear beat counter, go to `e_send`.
  - `e_send`: `lce_req_ready_o`=0, `lce_req_v_o`=1, `lce_req_last_o` = (count == N-1). On `lce_req_v_o & lce_req_ready_and_i`: if last, go to `e_ready`; else count+1, stay.
- Header output is the registered header, unchanged for all beats of a message.
- `lce_req_v_i` while `lce_req_ready_o`=0 is a protocol violation; ignored, no state change (simulation assertion flags it).
- Beat counter never wraps: bounded by N-1 <= `beats_lp`-1.
- Reset mid-message: asynchronously returns to `e_ready`; in-flight message discarded; no partial beats after reset deassertion.

## Timing
- Reset values: `lce_req_ready_o`=0 during reset, 1 on first cycle after deassertion; `lce_req_v_o`=0, `lce_req_last_o`=0, `lce_req_header_o`='0, `lce_req_data_o`='0.
- Latency: message accepted in cycle t -> first beat valid in cycle t+1 (registered outputs, no combinational path from `lce_req_i` to outputs).
- Throughput: N beats plus one `e_ready` cycle per message; best case N+1 cycles per message.
- `lce_req_v_o`, header, data and last depend only on registered state; none depend combinationally on `lce_req_ready_and_i`.
- `lce_req_ready_o` depends only on state; no combinational path from any input.
- Backpressure: while `lce_req_ready_and_i`=0, all outputs hold stable.

## Test plan
- Cached read, addr 0x8000_0040, `lce_req_ready_and_i` tied 1 -> one beat cycle t+1, last=1, data=0, header equals input; ready_o high again t+2.
- uc_wr size 8B, data 0xDEAD_BEEF_0123_4567 -> single beat, data beat 0 = 0xDEAD_BEEF_0123_4567, last=1.
- uc_wr size 64B with 512-bit block, `fill_width_p`=64, data bytes 0x00..0x3F -> 8 beats, beat k low byte = 8k, last only on beat 7, header identical on all beats.
- Same 64B message with `lce_req_ready_and_i` toggling 1,0,0,1,... -> outputs stable during stalls, exactly 8 handshakes, no beat skipped or repeated.
- Assert `reset_i` during beat 3 of an 8-beat message -> v_o=0 immediately; after release ready_o=1; next message streams from beat 0.
- Back-to-back amoadd (8B) then rd -> second accepted in cycle following first's last handshake; no lost or merged messages.
